pe_ctrl: RTL and testbench
==========================

Name: pe_ctrl

Overview:
Sequencer for one processing element in the clk_pe domain. It drains the filter and ifmap read-side FIFOs into their scratchpads, then runs a 1-D row convolution. Each output is sum over k of filt[k]*ifmap[o+k], plus one input psum popped from the psum FIFO. Results are emitted on a valid/ready port toward the psum output FIFO. The block owns all FIFO read enables and spad addr/we for the PE.

Parameters:
DATA_W, 16, signed ifmap/filter word width
PSUM_W, 32, signed psum/accumulator width (must be >= 2*DATA_W)
ADDR_W, 4, spad address width; spad depth DEPTH = 2**ADDR_W

Ports:
clk_pe in 1 PE clock, sole clock
rst_n in 1 synchronous active-low reset
start in 1 begin job; sampled only in IDLE
cfg_filt_len in ADDR_W filter taps S
cfg_ofmap_len in ADDR_W outputs per job O
busy out 1 high when state != IDLE
done out 1 one-cycle pulse at job end
cfg_err out 1 one-cycle pulse on rejected start
filt_fifo_empty in 1 / filt_fifo_rd_en out 1 / filt_fifo_rd_data in DATA_W
ifmap_fifo_empty in 1 / ifmap_fifo_rd_en out 1 / ifmap_fifo_rd_data in DATA_W
psum_fifo_empty in 1 / psum_fifo_rd_en out 1 / psum_fifo_rd_data in PSUM_W
filt_spad_addr out ADDR_W / filt_spad_we out 1 / filt_spad_wdata out DATA_W / filt_spad_rdata in DATA_W
ifmap_spad_addr out ADDR_W / ifmap_spad_we out 1 / ifmap_spad_wdata out DATA_W / ifmap_spad_rdata in DATA_W
out_psum out PSUM_W / out_psum_valid out 1 / out_psum_ready in 1

Behaviour:
- Interface timing: FIFO rd_data is valid the cycle after rd_en. Spad rdata is valid the cycle after addr with we=0.
- Reset (rst_n=0 at a clk_pe edge): state IDLE; all counters and the accumulator at 0. All outputs 0: rd_en, we, addr, wdata, out_psum, out_psum_valid, busy, done, cfg_err.
- Reset mid-job aborts at once. Spad contents are not cleared. Any FIFO word already popped is discarded.
- States: IDLE, LD_FILT, LD_IFMAP, MAC, PSUM, OUT.
- IDLE, start=1: S and O are latched.
  - Rejected if S==0, O==0, or S+O-1 > DEPTH (computed at ADDR_W+1 bits). Then cfg_err pulses and the state stays IDLE.
  - Otherwise go to LD_FILT.
- LD_FILT:
  - Issue rd_en when !empty and issued < S.
  - One cycle later: we=1, wdata=rd_data, addr=write index 0..S-1.
  - Throughput is 1 word/cycle with no stalls. An empty FIFO stalls issue only.
  - Leave when the S-th write completes.
- LD_IFMAP: same as LD_FILT with L = S+O-1 words to addresses 0..L-1.
- MAC: for output index o, issue reads k = 0..S-1, one per cycle.
  - filt_spad_addr = k; ifmap_spad_addr = o+k.
  - Next cycle: acc <= acc + sext(filt_rdata*ifmap_rdata) (signed DATA_W x DATA_W product).
  - acc is cleared on entry to MAC for each o.
  - The final accumulate lands on the first cycle of PSUM.
- PSUM:
  - Wait for !psum_fifo_empty, then pulse rd_en once.
  - Next cycle: acc <= acc + psum_rd_data, then go to OUT.
  - All additions wrap modulo 2**PSUM_W; no saturation.
- OUT:
  - out_psum = acc and out_psum_valid = 1, both held stable until out_psum_ready=1.
  - On the handshake cycle: valid drops next cycle and o increments.
  - If o == O-1: done pulses and the state goes to IDLE. Otherwise back to MAC.
- Latency with no stalls:
  - LD_FILT S+1 cycles; LD_IFMAP L+1 cycles.
  - Per output: S (MAC) + 2 (PSUM pop + add) + 1 (OUT with ready=1).
- start asserted while busy is ignored.
- rd_en is never asserted while the matching empty=1.
- Spad we is never asserted outside the LD states.

Decomposition:
- Shared package pe_pkg:
  - state enum (IDLE, LD_FILT, LD_IFMAP, MAC, PSUM, OUT)
  - default DATA_W/PSUM_W/ADDR_W localparams
- Sub-module spad_loader: FIFO-to-spad copier with count input, done output, and 1-cycle write pipeline.
  - Instantiated twice, for filt and ifmap.
  - The spad address muxes between loader and MAC in pe_ctrl.

Test Plan:
- Nominal job: S=3, O=3, filt={1,2,3}, ifmap={1,2,3,4,5}, psum FIFO={10,20,30}, ready=1.
  - Required: out_psum 24, 40, 56 in order, then a single done pulse.
  - Required: filt spad writes at addr 0..2 and ifmap spad writes at addr 0..4.
- Signed/wrap: S=1, O=1, filt=-2, ifmap=3, psum=5.
  - Required: out_psum = -1.
  - Separately, with PSUM_W=32, psum=0x7FFFFFFF, product 1. Required: out_psum = 0x80000000.
- Stalls: assert filt_fifo_empty and psum_fifo_empty for random 0-5 cycle gaps; hold ready=0 for 4 cycles on each output.
  - Required: results identical to the nominal job.
  - Required: no rd_en while empty; out_psum stable while valid && !ready.
- Bad config: start with S=0; then S=10, O=8 at DEPTH=16.
  - Required: cfg_err pulses for one cycle, busy stays 0, no FIFO pops.
- Boundary fill: S=4, O=13 (L=16=DEPTH).
  - Required: accepted; last ifmap write at addr 15; all 13 outputs correct vs. reference model.
- Reset mid-MAC: drop rst_n during the second output.
  - Required: next cycle all outputs 0 and busy=0.
  - Required: a following nominal job with refilled FIFOs gives 24, 40, 56.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default widths for the processing-element sequencer.
package pe_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int PSUM_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LD_FILT,
        LD_IFMAP,
        MAC,
        PSUM,
        OUT
    } state_t;
endpackage

// File: rtl/pe_ctrl_spad_loader.sv
// Copies `count` words from a read-side FIFO into a scratchpad at addresses 0..count-1.
module spad_loader
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W:0]   count,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic [ADDR_W-1:0] spad_addr,
    output logic              spad_we,
    output logic [DATA_W-1:0] spad_wdata,
    output logic              done
);
    localparam logic [ADDR_W:0] ONE = 1;

    logic [ADDR_W:0]   issued;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;

    // FIFO data lands one cycle after the pop, so the write trails the read by one cycle.
    assign fifo_rd_en = en && !fifo_empty && (issued < count);
    assign spad_we    = we_q;
    assign spad_addr  = addr_q;
    assign spad_wdata = we_q ? fifo_rd_data : '0;
    assign done       = we_q && ({1'b0, addr_q} == (count - ONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
        end else if (!en) begin
            issued <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            we_q <= fifo_rd_en;
            if (fifo_rd_en) begin
                issued <= issued + ONE;
                addr_q <= issued[ADDR_W-1:0];
            end
        end
    end
endmodule

// File: rtl/pe_ctrl.sv
// Processing-element sequencer: loads filter/ifmap scratchpads, runs a 1-D row
// convolution per output, adds an incoming psum and hands the result downstream.
//
// state    | meaning
// IDLE     | waiting for start; config checked and latched here
// LD_FILT  | copy S filter taps from FIFO into filter spad
// LD_IFMAP | copy S+O-1 ifmap words from FIFO into ifmap spad
// MAC      | issue S spad reads for current output, accumulate one cycle behind
// PSUM     | pop one input psum and add it to the accumulator
// OUT      | present result until out_psum_ready
module pe_ctrl
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_pe,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_filt_len,
    input  logic [ADDR_W-1:0] cfg_ofmap_len,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic              filt_fifo_empty,
    output logic              filt_fifo_rd_en,
    input  logic [DATA_W-1:0] filt_fifo_rd_data,
    input  logic              ifmap_fifo_empty,
    output logic              ifmap_fifo_rd_en,
    input  logic [DATA_W-1:0] ifmap_fifo_rd_data,
    input  logic              psum_fifo_empty,
    output logic              psum_fifo_rd_en,
    input  logic [PSUM_W-1:0] psum_fifo_rd_data,
    output logic [ADDR_W-1:0] filt_spad_addr,
    output logic              filt_spad_we,
    output logic [DATA_W-1:0] filt_spad_wdata,
    input  logic [DATA_W-1:0] filt_spad_rdata,
    output logic [ADDR_W-1:0] ifmap_spad_addr,
    output logic              ifmap_spad_we,
    output logic [DATA_W-1:0] ifmap_spad_wdata,
    input  logic [DATA_W-1:0] ifmap_spad_rdata,
    output logic [PSUM_W-1:0] out_psum,
    output logic              out_psum_valid,
    input  logic              out_psum_ready
);
    localparam logic [ADDR_W:0]   ONE     = 1;
    localparam logic [ADDR_W-1:0] ONE_A   = 1;
    localparam logic [ADDR_W:0]   DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] s_q;
    logic [ADDR_W-1:0] o_q;
    logic [ADDR_W:0]   l_q;
    logic [ADDR_W-1:0] o_idx;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] mac_faddr;
    logic [ADDR_W-1:0] mac_iaddr;
    logic              mac_v;
    logic              psum_popped;
    logic              psum_rd_q;
    logic [PSUM_W-1:0] acc;

    logic [ADDR_W:0]   cfg_span;
    logic              cfg_bad;
    logic [ADDR_W-1:0] filt_ld_addr;
    logic [ADDR_W-1:0] ifmap_ld_addr;
    logic              filt_ld_done;
    logic              ifmap_ld_done;
    logic [PSUM_W-1:0] filt_ext;
    logic [PSUM_W-1:0] ifmap_ext;
    logic [PSUM_W-1:0] prod;

    assign cfg_span = {1'b0, cfg_filt_len} + {1'b0, cfg_ofmap_len} - ONE;
    assign cfg_bad  = (cfg_filt_len == '0) || (cfg_ofmap_len == '0) || (cfg_span > DEPTH_V);

    // Sign-extended operands make the truncated product equal the signed product.
    assign filt_ext  = {{(PSUM_W-DATA_W){filt_spad_rdata[DATA_W-1]}}, filt_spad_rdata};
    assign ifmap_ext = {{(PSUM_W-DATA_W){ifmap_spad_rdata[DATA_W-1]}}, ifmap_spad_rdata};
    assign prod      = filt_ext * ifmap_ext;

    assign busy            = (state != IDLE);
    assign psum_fifo_rd_en = (state == PSUM) && !psum_popped && !psum_fifo_empty;
    assign filt_spad_addr  = (state == LD_FILT)  ? filt_ld_addr  :
                             (state == MAC)      ? mac_faddr     : '0;
    assign ifmap_spad_addr = (state == LD_IFMAP) ? ifmap_ld_addr :
                             (state == MAC)      ? mac_iaddr     : '0;

    spad_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_filt_ld (
        .clk          (clk_pe),
        .rst_n        (rst_n),
        .en           (state == LD_FILT),
        .count        ({1'b0, s_q}),
        .fifo_empty   (filt_fifo_empty),
        .fifo_rd_en   (filt_fifo_rd_en),
        .fifo_rd_data (filt_fifo_rd_data),
        .spad_addr    (filt_ld_addr),
        .spad_we      (filt_spad_we),
        .spad_wdata   (filt_spad_wdata),
        .done         (filt_ld_done)
    );

    spad_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ifmap_ld (
        .clk          (clk_pe),
        .rst_n        (rst_n),
        .en           (state == LD_IFMAP),
        .count        (l_q),
        .fifo_empty   (ifmap_fifo_empty),
        .fifo_rd_en   (ifmap_fifo_rd_en),
        .fifo_rd_data (ifmap_fifo_rd_data),
        .spad_addr    (ifmap_ld_addr),
        .spad_we      (ifmap_spad_we),
        .spad_wdata   (ifmap_spad_wdata),
        .done         (ifmap_ld_done)
    );

    always_ff @(posedge clk_pe) begin
        if (!rst_n) begin
            state          <= IDLE;
            s_q            <= '0;
            o_q            <= '0;
            l_q            <= '0;
            o_idx          <= '0;
            k              <= '0;
            mac_faddr      <= '0;
            mac_iaddr      <= '0;
            mac_v          <= 1'b0;
            psum_popped    <= 1'b0;
            psum_rd_q      <= 1'b0;
            acc            <= '0;
            out_psum       <= '0;
            out_psum_valid <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            mac_v     <= (state == MAC);
            psum_rd_q <= psum_fifo_rd_en;
            // Spad data trails the address by a cycle; the last product lands in PSUM.
            if (mac_v) begin
                acc <= acc + prod;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        s_q <= cfg_filt_len;
                        o_q <= cfg_ofmap_len;
                        l_q <= cfg_span;
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            o_idx <= '0;
                            state <= LD_FILT;
                        end
                    end
                end
                LD_FILT: begin
                    if (filt_ld_done) begin
                        state <= LD_IFMAP;
                    end
                end
                LD_IFMAP: begin
                    if (ifmap_ld_done) begin
                        acc       <= '0;
                        k         <= '0;
                        mac_faddr <= '0;
                        mac_iaddr <= '0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    if (k == s_q - ONE_A) begin
                        state <= PSUM;
                    end else begin
                        k         <= k + ONE_A;
                        mac_faddr <= mac_faddr + ONE_A;
                        mac_iaddr <= mac_iaddr + ONE_A;
                    end
                end
                PSUM: begin
                    if (psum_fifo_rd_en) begin
                        psum_popped <= 1'b1;
                    end
                    if (psum_rd_q) begin
                        acc            <= acc + psum_fifo_rd_data;
                        out_psum       <= acc + psum_fifo_rd_data;
                        out_psum_valid <= 1'b1;
                        psum_popped    <= 1'b0;
                        state          <= OUT;
                    end
                end
                OUT: begin
                    if (out_psum_ready) begin
                        out_psum       <= '0;
                        out_psum_valid <= 1'b0;
                        if (o_idx == o_q - ONE_A) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            o_idx     <= o_idx + ONE_A;
                            acc       <= '0;
                            k         <= '0;
                            mac_faddr <= '0;
                            mac_iaddr <= o_idx + ONE_A;
                            state     <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_ctrl.sv
// Directed self-checking bench for pe_ctrl with FIFO and scratchpad behavioural models.
module tb_pe_ctrl;
    localparam int DATA_W = 16;
    localparam int PSUM_W = 32;
    localparam int ADDR_W = 4;

    logic              clk_pe = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_filt_len = '0;
    logic [ADDR_W-1:0] cfg_ofmap_len = '0;
    logic              busy, done, cfg_err;
    logic              filt_fifo_empty, filt_fifo_rd_en;
    logic [DATA_W-1:0] filt_fifo_rd_data = '0;
    logic              ifmap_fifo_empty, ifmap_fifo_rd_en;
    logic [DATA_W-1:0] ifmap_fifo_rd_data = '0;
    logic              psum_fifo_empty, psum_fifo_rd_en;
    logic [PSUM_W-1:0] psum_fifo_rd_data = '0;
    logic [ADDR_W-1:0] filt_spad_addr, ifmap_spad_addr;
    logic              filt_spad_we, ifmap_spad_we;
    logic [DATA_W-1:0] filt_spad_wdata, ifmap_spad_wdata;
    logic [DATA_W-1:0] filt_spad_rdata = '0;
    logic [DATA_W-1:0] ifmap_spad_rdata = '0;
    logic [PSUM_W-1:0] out_psum;
    logic              out_psum_valid;
    logic              out_psum_ready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_pe = ~clk_pe;

    pe_ctrl #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .ADDR_W(ADDR_W)) dut (
        .clk_pe(clk_pe), .rst_n(rst_n), .start(start),
        .cfg_filt_len(cfg_filt_len), .cfg_ofmap_len(cfg_ofmap_len),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .filt_fifo_empty(filt_fifo_empty), .filt_fifo_rd_en(filt_fifo_rd_en),
        .filt_fifo_rd_data(filt_fifo_rd_data),
        .ifmap_fifo_empty(ifmap_fifo_empty), .ifmap_fifo_rd_en(ifmap_fifo_rd_en),
        .ifmap_fifo_rd_data(ifmap_fifo_rd_data),
        .psum_fifo_empty(psum_fifo_empty), .psum_fifo_rd_en(psum_fifo_rd_en),
        .psum_fifo_rd_data(psum_fifo_rd_data),
        .filt_spad_addr(filt_spad_addr), .filt_spad_we(filt_spad_we),
        .filt_spad_wdata(filt_spad_wdata), .filt_spad_rdata(filt_spad_rdata),
        .ifmap_spad_addr(ifmap_spad_addr), .ifmap_spad_we(ifmap_spad_we),
        .ifmap_spad_wdata(ifmap_spad_wdata), .ifmap_spad_rdata(ifmap_spad_rdata),
        .out_psum(out_psum), .out_psum_valid(out_psum_valid), .out_psum_ready(out_psum_ready)
    );

    // FIFO models: rd_data valid the cycle after rd_en; flush discards unread words.
    logic [DATA_W-1:0] filt_mem [256];
    logic [DATA_W-1:0] ifmap_mem [256];
    logic [PSUM_W-1:0] psum_mem [256];
    int filt_wr = 0, filt_rd = 0, ifmap_wr = 0, ifmap_rd = 0, psum_wr = 0, psum_rd = 0;
    logic flush = 1'b0;
    logic filt_stall = 1'b0, psum_stall = 1'b0;

    assign filt_fifo_empty  = filt_stall || (filt_rd == filt_wr);
    assign ifmap_fifo_empty = (ifmap_rd == ifmap_wr);
    assign psum_fifo_empty  = psum_stall || (psum_rd == psum_wr);

    always @(posedge clk_pe) begin
        if (flush) begin
            filt_rd  <= filt_wr;
            ifmap_rd <= ifmap_wr;
            psum_rd  <= psum_wr;
        end else begin
            if (filt_fifo_rd_en) begin
                filt_fifo_rd_data <= filt_mem[filt_rd % 256];
                filt_rd <= filt_rd + 1;
            end
            if (ifmap_fifo_rd_en) begin
                ifmap_fifo_rd_data <= ifmap_mem[ifmap_rd % 256];
                ifmap_rd <= ifmap_rd + 1;
            end
            if (psum_fifo_rd_en) begin
                psum_fifo_rd_data <= psum_mem[psum_rd % 256];
                psum_rd <= psum_rd + 1;
            end
        end
    end

    logic [DATA_W-1:0] filt_spad [16];
    logic [DATA_W-1:0] ifmap_spad [16];
    always @(posedge clk_pe) begin
        if (filt_spad_we) filt_spad[filt_spad_addr] <= filt_spad_wdata;
        if (ifmap_spad_we) ifmap_spad[ifmap_spad_addr] <= ifmap_spad_wdata;
        filt_spad_rdata  <= filt_spad[filt_spad_addr];
        ifmap_spad_rdata <= ifmap_spad[ifmap_spad_addr];
    end

    // Stall and back-pressure generator
    logic stall_mode = 1'b0, hold_mode = 1'b0;
    int fgap = 0, pgap = 0, hold_cnt = 0;
    always @(negedge clk_pe) begin
        if (stall_mode) begin
            if (fgap > 0) begin filt_stall = 1'b1; fgap--; end
            else begin filt_stall = 1'b0; if ($urandom_range(0, 2) == 0) fgap = $urandom_range(0, 5); end
            if (pgap > 0) begin psum_stall = 1'b1; pgap--; end
            else begin psum_stall = 1'b0; if ($urandom_range(0, 2) == 0) pgap = $urandom_range(0, 5); end
        end else begin
            filt_stall = 1'b0;
            psum_stall = 1'b0;
        end
        if (!hold_mode) out_psum_ready = 1'b1;
        else if (out_psum_valid) begin
            if (hold_cnt < 4) begin out_psum_ready = 1'b0; hold_cnt++; end
            else out_psum_ready = 1'b1;
        end else begin
            out_psum_ready = 1'b0;
            hold_cnt = 0;
        end
    end

    // Monitor, sampled mid low phase
    logic [PSUM_W-1:0] rx [64];
    int rx_cnt = 0, done_cnt = 0, err_cycles = 0, busy_cycles = 0, pop_cnt = 0;
    int fw_total = 0, iw_total = 0, fw_idx = 0, iw_idx = 0;
    int waddr_viol = 0, empty_viol = 0, stable_viol = 0;
    logic [ADDR_W-1:0] last_iw_addr = '0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [PSUM_W-1:0] prev_out = '0;
    always @(negedge clk_pe) begin
        #2;
        if (out_psum_valid && out_psum_ready) begin rx[rx_cnt % 64] = out_psum; rx_cnt++; end
        if (done) done_cnt++;
        if (cfg_err) err_cycles++;
        if (busy) busy_cycles++;
        if (filt_fifo_rd_en || ifmap_fifo_rd_en || psum_fifo_rd_en) pop_cnt++;
        if ((filt_fifo_rd_en && filt_fifo_empty) || (ifmap_fifo_rd_en && ifmap_fifo_empty) ||
            (psum_fifo_rd_en && psum_fifo_empty)) empty_viol++;
        if (!busy) begin fw_idx = 0; iw_idx = 0; end
        if (filt_spad_we) begin
            if (filt_spad_addr != 4'(fw_idx)) waddr_viol++;
            fw_idx++; fw_total++;
        end
        if (ifmap_spad_we) begin
            if (ifmap_spad_addr != 4'(iw_idx)) waddr_viol++;
            iw_idx++; iw_total++;
            last_iw_addr = ifmap_spad_addr;
        end
        if (prev_valid && !prev_ready && out_psum_valid && out_psum !== prev_out) stable_viol++;
        prev_valid = out_psum_valid;
        prev_ready = out_psum_ready;
        prev_out   = out_psum;
    end

    logic [DATA_W-1:0] jf [16];
    logic [DATA_W-1:0] ji [16];
    logic [PSUM_W-1:0] jp [16];
    logic [PSUM_W-1:0] jexp [16];

    function automatic logic [PSUM_W-1:0] ref_out(input int s, input int o);
        int a = 0;
        for (int kk = 0; kk < s; kk++)
            a += int'($signed(jf[kk])) * int'($signed(ji[o + kk]));
        a += int'(jp[o]);
        return a;
    endfunction

    task automatic load_fifos(input int s, input int o);
        for (int n = 0; n < s; n++) begin filt_mem[filt_wr % 256] = jf[n]; filt_wr++; end
        for (int n = 0; n < s + o - 1; n++) begin ifmap_mem[ifmap_wr % 256] = ji[n]; ifmap_wr++; end
        for (int n = 0; n < o; n++) begin psum_mem[psum_wr % 256] = jp[n]; psum_wr++; end
    endtask

    task automatic do_flush();
        @(negedge clk_pe); flush = 1'b1;
        @(negedge clk_pe); flush = 1'b0;
    endtask

    task automatic pulse_start(input int s, input int o);
        @(negedge clk_pe);
        cfg_filt_len  = 4'(s);
        cfg_ofmap_len = 4'(o);
        start = 1'b1;
        @(negedge clk_pe);
        start = 1'b0;
    endtask

    task automatic run_and_check(input int s, input int o, input string name);
        int rb = rx_cnt, db = done_cnt, fb = fw_total, ib = iw_total, cyc = 0;
        load_fifos(s, o);
        pulse_start(s, o);
        while (done_cnt == db && cyc < 3000) begin @(negedge clk_pe); cyc++; end
        n_checks++;
        if (done_cnt == db) begin
            n_fail++;
            $display("FAIL %s done_timeout: no done after %0d cycles", name, cyc);
        end
        repeat (3) @(negedge clk_pe);
        n_checks++;
        if (rx_cnt - rb !== o) begin
            n_fail++;
            $display("FAIL %s out_count: got %0d expected %0d", name, rx_cnt - rb, o);
        end
        for (int j = 0; j < o; j++) begin
            n_checks++;
            if (rx[(rb + j) % 64] !== jexp[j]) begin
                n_fail++;
                $display("FAIL %s out[%0d]: got %h expected %h", name, j, rx[(rb + j) % 64], jexp[j]);
            end
        end
        n_checks++;
        if (done_cnt - db !== 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - db);
        end
        n_checks++;
        if (fw_total - fb !== s || iw_total - ib !== s + o - 1) begin
            n_fail++;
            $display("FAIL %s spad_writes: got filt %0d ifmap %0d expected %0d %0d",
                     name, fw_total - fb, iw_total - ib, s, s + o - 1);
        end
    endtask

    task automatic set_nominal();
        jf[0] = 16'd1; jf[1] = 16'd2; jf[2] = 16'd3;
        for (int n = 0; n < 5; n++) ji[n] = 16'(n + 1);
        jp[0] = 32'd10; jp[1] = 32'd20; jp[2] = 32'd30;
        jexp[0] = 32'd24; jexp[1] = 32'd40; jexp[2] = 32'd56;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_pe);
        n_checks++;
        if ({busy, done, cfg_err, out_psum_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 0000", {busy, done, cfg_err, out_psum_valid});
        end
        n_checks++;
        if ({filt_fifo_rd_en, ifmap_fifo_rd_en, psum_fifo_rd_en, filt_spad_we, ifmap_spad_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_enables: got %b expected 00000",
                     {filt_fifo_rd_en, ifmap_fifo_rd_en, psum_fifo_rd_en, filt_spad_we, ifmap_spad_we});
        end
        n_checks++;
        if ({filt_spad_addr, ifmap_spad_addr, filt_spad_wdata, ifmap_spad_wdata, out_psum} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h %h wdata %h %h out %h expected all zero",
                     filt_spad_addr, ifmap_spad_addr, filt_spad_wdata, ifmap_spad_wdata, out_psum);
        end
        rst_n = 1'b1;
        @(negedge clk_pe);
    endtask

    task automatic test_nominal();
        int wv = waddr_viol;
        set_nominal();
        run_and_check(3, 3, "nominal");
        n_checks++;
        if (waddr_viol !== wv) begin
            n_fail++;
            $display("FAIL nominal_waddr: got %0d bad write addresses expected 0", waddr_viol - wv);
        end
    endtask

    task automatic test_signed_wrap();
        jf[0] = 16'hFFFE; ji[0] = 16'd3; jp[0] = 32'd5; jexp[0] = 32'hFFFF_FFFF;
        run_and_check(1, 1, "signed");
        jf[0] = 16'd1; ji[0] = 16'd1; jp[0] = 32'h7FFF_FFFF; jexp[0] = 32'h8000_0000;
        run_and_check(1, 1, "wrap");
    endtask

    task automatic test_stalls();
        int ev = empty_viol, sv = stable_viol;
        set_nominal();
        stall_mode = 1'b1;
        hold_mode  = 1'b1;
        run_and_check(3, 3, "stalls");
        stall_mode = 1'b0;
        hold_mode  = 1'b0;
        n_checks++;
        if (empty_viol !== ev) begin
            n_fail++;
            $display("FAIL stalls_rd_en_while_empty: got %0d events expected 0", empty_viol - ev);
        end
        n_checks++;
        if (stable_viol !== sv) begin
            n_fail++;
            $display("FAIL stalls_out_stable: got %0d changes expected 0", stable_viol - sv);
        end
    endtask

    task automatic bad_cfg(input int s, input int o, input string name);
        int eb = err_cycles, bb = busy_cycles, pb = pop_cnt;
        pulse_start(s, o);
        repeat (6) @(negedge clk_pe);
        n_checks++;
        if (err_cycles - eb !== 1) begin
            n_fail++;
            $display("FAIL %s cfg_err_cycles: got %0d expected 1", name, err_cycles - eb);
        end
        n_checks++;
        if (busy_cycles - bb !== 0) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected 0", name, busy_cycles - bb);
        end
        n_checks++;
        if (pop_cnt - pb !== 0) begin
            n_fail++;
            $display("FAIL %s fifo_pops: got %0d expected 0", name, pop_cnt - pb);
        end
    endtask

    task automatic test_bad_config();
        set_nominal();
        load_fifos(1, 1);
        bad_cfg(0, 3, "bad_s0");
        bad_cfg(10, 8, "bad_span");
        do_flush();
    endtask

    task automatic test_boundary_fill();
        jf[0] = 16'd3; jf[1] = 16'hFFFF; jf[2] = 16'd2; jf[3] = 16'd5;
        for (int n = 0; n < 16; n++) ji[n] = 16'(n * 7 - 20);
        for (int n = 0; n < 13; n++) jp[n] = 32'(n * 100 - 300);
        for (int n = 0; n < 13; n++) jexp[n] = ref_out(4, n);
        run_and_check(4, 13, "boundary");
        n_checks++;
        if (last_iw_addr !== 4'd15) begin
            n_fail++;
            $display("FAIL boundary_last_addr: got %0d expected 15", last_iw_addr);
        end
    endtask

    task automatic test_reset_mid_mac();
        int rb = rx_cnt, cyc = 0;
        set_nominal();
        load_fifos(3, 3);
        pulse_start(3, 3);
        while (rx_cnt == rb && cyc < 200) begin @(negedge clk_pe); cyc++; end
        n_checks++;
        if (rx_cnt == rb) begin
            n_fail++;
            $display("FAIL reset_mid_first_out: got 0 outputs expected 1 within %0d cycles", cyc);
        end
        rst_n = 1'b0;
        @(negedge clk_pe);
        n_checks++;
        if ({busy, done, cfg_err, out_psum_valid, filt_fifo_rd_en, ifmap_fifo_rd_en,
             psum_fifo_rd_en, filt_spad_we, ifmap_spad_we} !== 9'b0 ||
            {filt_spad_addr, ifmap_spad_addr, out_psum} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy %b valid %b addr %h %h out %h expected all zero",
                     busy, out_psum_valid, filt_spad_addr, ifmap_spad_addr, out_psum);
        end
        rst_n = 1'b1;
        do_flush();
        set_nominal();
        run_and_check(3, 3, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_signed_wrap();
        test_stalls();
        test_bad_config();
        test_boundary_fill();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
